mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port and its data port. It sits between `pipeline` and a single-port memory, replacing the dual-port memory in a reduced-area system. It serialises requests, drives the memory for a configurable number of wait cycles, and returns a one-cycle ready pulse with the read data to the winning requester. The pipeline stalls on each port until that port's ready pulse.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 1, memory access cycles per transfer, ≥1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_read_en`  in  1  instruction fetch request, held until `i_ready`
- `i_addr`  in  ADDR_W  fetch address
- `i_instr_out`  out  DATA_W  fetched instruction, valid while `i_ready`=1
- `i_ready`  out  1  one-cycle completion pulse for fetch
- `d_read_en`  in  1  data read request, held until `d_ready`
- `d_write_en`  in  1  data write request, held until `d_ready`
- `d_addr`  in  ADDR_W  data address
- `d_write_data`  in  DATA_W  store data
- `d_data_out`  out  DATA_W  load data, valid while `d_ready`=1
- `d_ready`  out  1  one-cycle completion pulse for load or store
- `m_read_en`  out  1  memory read strobe
- `m_write_en`  out  1  memory write strobe
- `m_addr`  out  ADDR_W  memory address
- `m_write_data`  out  DATA_W  memory write data
- `m_data_in`  in  DATA_W  memory read data, valid in the last ACCESS cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request pending: stay in IDLE.
  - Any request pending: the picker chooses an owner. Latch owner, address, write data and the read/write kind into registers that drive `m_*`. Load the counter with `WAIT_CYCLES`. Go to ACCESS.
- **ACCESS**
  - `m_*` stay stable for the whole state.
  - The counter decrements at each edge.
  - At the edge where counter==1: capture `m_data_in` into the owner's output data register (reads only), clear `m_read_en`/`m_write_en`, go to RESP.
- **RESP**
  - The owner's ready output is 1 for exactly this cycle.
  - Next state is always IDLE. This gives the requester one edge to drop or change its request before it is sampled again.
- **Arbitration (default):** fixed data priority. When both ports request in IDLE, the data port wins.
- **Simultaneous `d_read_en` and `d_write_en`:** treated as a write. `d_data_out` is unchanged.
- **Write completion:** `d_ready` pulses and `d_data_out` holds its previous value.
- **Request withdrawn during ACCESS:** the access still completes and the ready pulse still occurs. Requests are never aborted.
- **Output data registers:** hold their last value outside RESP.

## Timing
- Request first high in cycle 0 with the FSM in IDLE:
  - `m_*` driven in cycles 1..`WAIT_CYCLES`.
  - Ready pulse in cycle `WAIT_CYCLES`+1.
  - Latency is `WAIT_CYCLES`+1 cycles.
- Throughput is one transfer per `WAIT_CYCLES`+2 cycles.
- A losing requester waits at least one full transfer.
- Reset values (all outputs registered): `i_ready`=0, `d_ready`=0, `m_read_en`=0, `m_write_en`=0, `m_addr`=0, `m_write_data`=0, `i_instr_out`=0, `d_data_out`=0. FSM=IDLE, counter=0, last-grant=instruction.
- Reset asserted mid-ACCESS: all outputs clear asynchronously. The transfer is lost and no ready pulse occurs. The first request after reset release is sampled at the first rising edge with `rst`=1.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** a last-grant flop is kept. On contention the port not granted last wins. The flop updates on every grant, contended or not.
- **Undefined:** fixed data priority and no last-grant flop. A continuous data stream may starve fetch; the pipeline prevents this by construction.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE/ACCESS/RESP) and owner encoding (OWN_I, OWN_D).
- Sub-module `mem_arb_pick`: combinational picker.
  - Inputs: `i_req`, `d_req`, `last_grant`.
  - Outputs: `grant_valid`, `grant_owner`.
  - Contains the only `MEM_ARB_ROUND_ROBIN_EN`-dependent logic.

## Test plan
- **Fetch alone:** `WAIT_CYCLES`=2, fetch at 0x100 with `m_data_in`=0x8C010004 → `m_read_en`=1 in cycles 1–2, `i_ready`=1 in cycle 3, `i_instr_out`=0x8C010004.
- **Store:** store 0xDEADBEEF to 0x40 → `m_write_en`=1 with `m_addr`=0x40 and `m_write_data`=0xDEADBEEF for 2 cycles; `d_ready` pulses; `d_data_out` unchanged.
- **Contention, macro off:** fetch and load both requested in cycle 0 → load served first (`d_ready` cycle 3), then fetch (`i_ready` cycle 7).
- **Contention, `MEM_ARB_ROUND_ROBIN_EN` defined:** both requests held continuously → grants alternate D, I, D, I.
- **Reset mid-ACCESS:** assert `rst`=0 in cycle 1 of a load → `m_read_en`=0 immediately, no `d_ready`; after release, a new fetch completes normally.
- **Read and write together:** `d_read_en`=`d_write_en`=1 → a single write is performed and `d_data_out` keeps its old value.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational request picker. Fixed data priority by default; alternating
// priority on contention when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_owner
);

  // Choose the owner of the next transfer from the pending requests
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      if (last_grant == OWN_D) begin
        grant_owner = OWN_I;
      end else begin
        grant_owner = OWN_D;
      end
    end else if (d_req) begin
      grant_owner = OWN_D;
    end else begin
      grant_owner = OWN_I;
    end
`else
    if (d_req) begin
      grant_owner = OWN_D;
    end else begin
      grant_owner = OWN_I;
    end
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = 1'(last_grant);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between fetch and data ports.
// Optional contention policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_instr_out,
  output logic              i_ready,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_write_data,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_ready,
  output logic              m_read_en,
  output logic              m_write_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_write_data,
  input  logic [DATA_W-1:0] m_data_in
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  arb_state_e        state_r;
  arb_state_e        next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  owner_e            owner_r;
  owner_e            last_grant_r;
  logic              d_req_s;
  logic              grant_valid_s;
  owner_e            grant_owner_s;

  assign d_req_s = d_read_en | d_write_en;

  mem_arb_pick u_pick (
    .i_req       (i_read_en),
    .d_req       (d_req_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_owner (grant_owner_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; RESP always returns to IDLE so requesters get one edge to update
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_W'(1)) begin
          next_state_s = RESP;
        end else begin
          next_state_s = ACCESS;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Transfer datapath: latch the grant, drive memory, capture read data and pulse ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= '0;
      owner_r      <= OWN_I;
      last_grant_r <= OWN_I;
      m_read_en    <= 1'b0;
      m_write_en   <= 1'b0;
      m_addr       <= '0;
      m_write_data <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_instr_out  <= '0;
      d_data_out   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          if (grant_valid_s) begin
            owner_r      <= grant_owner_s;
            last_grant_r <= grant_owner_s;
            cnt_r        <= CNT_W'(WAIT_CYCLES);
            if (grant_owner_s == OWN_D) begin
              // a combined read+write request is served as a write
              m_addr       <= d_addr;
              m_write_data <= d_write_data;
              m_write_en   <= d_write_en;
              m_read_en    <= ~d_write_en;
            end else begin
              m_addr     <= i_addr;
              m_write_en <= 1'b0;
              m_read_en  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            m_read_en  <= 1'b0;
            m_write_en <= 1'b0;
            if (owner_r == OWN_D) begin
              d_ready <= 1'b1;
              if (m_read_en) begin
                d_data_out <= m_data_in;
              end
            end else begin
              i_ready <= 1'b1;
              if (m_read_en) begin
                i_instr_out <= m_data_in;
              end
            end
          end
        end
        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
        end
        default: begin
          i_ready    <= 1'b0;
          d_ready    <= 1'b0;
          m_read_en  <= 1'b0;
          m_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected transfers, a monitor
// checks each ready pulse against a transaction-level model of memory and arbitration.
module tb_mem_arbiter;

  localparam int W    = 2;
  localparam int MAXC = 8192;

  typedef struct packed {
    logic        is_w;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_en, d_read_en, d_write_en;
  logic [31:0] i_addr, d_addr, d_write_data;
  logic [31:0] i_instr_out, d_data_out, m_addr, m_write_data, m_data_in;
  logic        i_ready, d_ready, m_read_en, m_write_en;

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  int env_cnt = 0;
  bit hist_i [MAXC];
  bit hist_d [MAXC];
  logic [31:0] ref_mem [8];
  logic [31:0] env_mem [8];
  txn_t exp_i [$];
  txn_t exp_d [$];

  int          t_prev = -1;
  int          lastw = 0;
  int          scount = 0;
  logic        s_w = 1'b0, s_bad = 1'b0;
  logic [31:0] s_addr = '0, s_wd = '0;
  logic [31:0] last_i = '0, last_d = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_instr_out(i_instr_out), .i_ready(i_ready),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_data_out(d_data_out), .d_ready(d_ready),
    .m_read_en(m_read_en), .m_write_en(m_write_en), .m_addr(m_addr),
    .m_write_data(m_write_data), .m_data_in(m_data_in)
  );

  // Memory environment: data is only valid in the last strobe cycle
  assign m_data_in = (m_read_en && env_cnt == W - 1) ? env_mem[m_addr[4:2]]
                                                      : (32'hA5A5_0000 ^ 32'(env_cnt));
  always @(posedge clk) begin
    if (m_read_en || m_write_en) begin
      if (m_write_en && env_cnt == W - 1) env_mem[m_addr[4:2]] <= m_write_data;
      env_cnt <= env_cnt + 1;
    end else begin
      env_cnt <= 0;
    end
  end

  // Request history per cycle, as sampled by the DUT at the closing edge
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      hist_i[cyc] <= i_read_en;
      hist_d[cyc] <= d_read_en | d_write_en;
    end
    cyc <= cyc + 1;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic check_resp(input int port);
    txn_t e;
    int t, g, exp_w;
    bit own, oth, idle_bad;
    logic [2:0] idx;
    t = cyc;
    g = t - W - 1;
    if ((port == 0 && exp_i.size() == 0) || (port == 1 && exp_d.size() == 0)) begin
      chk(port == 1 ? "unexpected_d_ready" : "unexpected_i_ready", 64'd1, 64'd0);
      return;
    end
    if (port == 1) e = exp_d.pop_front();
    else e = exp_i.pop_front();
    chk("strobe_cycles", 64'(scount), 64'(W));
    chk("strobe_stable", 64'(s_bad), 64'd0);
    chk("m_addr", 64'(s_addr), 64'(e.addr));
    chk("m_kind", 64'(s_w), 64'(e.is_w));
    if (e.is_w) chk("m_write_data", 64'(s_wd), 64'(e.wdata));
    own = 1'b0;
    oth = 1'b0;
    idle_bad = (g <= t_prev) || (g < 0);
    if (g >= 0 && g < MAXC) begin
      own = (port == 1) ? hist_d[g] : hist_i[g];
      oth = (port == 1) ? hist_i[g] : hist_d[g];
      for (int c = t_prev + 1; c < g; c++) if (hist_i[c] || hist_d[c]) idle_bad = 1'b1;
    end
    chk("req_at_grant", 64'(own), 64'd1);
    chk("grant_timing", 64'(idle_bad), 64'd0);
    if (oth) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = (lastw == 0) ? 1 : 0;
`else
      exp_w = 1;
`endif
      chk("arb_winner", 64'(port), 64'(exp_w));
    end
    lastw  = port;
    t_prev = t;
    idx = e.addr[4:2];
    if (port == 0) begin
      chk("i_instr_out", 64'(i_instr_out), 64'(ref_mem[idx]));
      last_i = ref_mem[idx];
      chk("d_data_hold", 64'(d_data_out), 64'(last_d));
    end else if (e.is_w) begin
      chk("d_data_keep_on_write", 64'(d_data_out), 64'(last_d));
      ref_mem[idx] = e.wdata;
      chk("i_instr_hold", 64'(i_instr_out), 64'(last_i));
    end else begin
      chk("d_data_out", 64'(d_data_out), 64'(ref_mem[idx]));
      last_d = ref_mem[idx];
      chk("i_instr_hold", 64'(i_instr_out), 64'(last_i));
    end
  endtask

  // Monitor: samples just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      scount = 0; s_bad = 1'b0; last_i = '0; last_d = '0; lastw = 0;
      t_prev = cyc - 1;
    end else begin
      if (m_read_en || m_write_en) begin
        if (scount == 0) begin
          s_addr = m_addr; s_w = m_write_en; s_wd = m_write_data;
          s_bad  = m_read_en & m_write_en;
        end else if (m_addr !== s_addr || m_write_en !== s_w || m_read_en === m_write_en ||
                     (s_w && m_write_data !== s_wd)) begin
          s_bad = 1'b1;
        end
        scount++;
      end
      if (i_ready || d_ready) begin
        chk("ready_exclusive", 64'(i_ready & d_ready), 64'd0);
        check_resp(d_ready ? 1 : 0);
        scount = 0;
        s_bad  = 1'b0;
      end else begin
        chk("i_instr_hold", 64'(i_instr_out), 64'(last_i));
        chk("d_data_hold", 64'(d_data_out), 64'(last_d));
      end
    end
  end

  task automatic issue_i(input logic [31:0] a);
    txn_t e;
    i_read_en = 1'b1; i_addr = a;
    e.is_w = 1'b0; e.addr = a; e.wdata = '0;
    exp_i.push_back(e);
  endtask

  task automatic issue_d(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    txn_t e;
    d_read_en = rd; d_write_en = wr; d_addr = a; d_write_data = wd;
    e.is_w = wr; e.addr = a; e.wdata = wd;
    exp_d.push_back(e);
  endtask

  task automatic wait_i();
    int n = 0;
    do begin @(negedge clk); n++; end while (!i_ready && n < 200);
    if (!i_ready) chk("i_ready_timeout", 64'(i_ready), 64'd1);
  endtask

  task automatic wait_d();
    int n = 0;
    do begin @(negedge clk); n++; end while (!d_ready && n < 200);
    if (!d_ready) chk("d_ready_timeout", 64'(d_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b0;
    i_read_en = 1'b0; d_read_en = 1'b0; d_write_en = 1'b0;
    i_addr = '0; d_addr = '0; d_write_data = '0;
    for (int k = 0; k < 8; k++) begin
      v = $urandom;
      ref_mem[k] = v;
      env_mem[k] <= v;
    end
    ref_mem[0] = 32'h8C01_0004;
    env_mem[0] <= 32'h8C01_0004;

    repeat (3) @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_m_read_en", 64'(m_read_en), 64'd0);
    chk("rst_m_write_en", 64'(m_write_en), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_write_data", 64'(m_write_data), 64'd0);
    chk("rst_i_instr_out", 64'(i_instr_out), 64'd0);
    chk("rst_d_data_out", 64'(d_data_out), 64'd0);
    rst = 1'b1;

    @(negedge clk);
    issue_i(32'h0000_0100); wait_i(); i_read_en = 1'b0;
    repeat (2) @(negedge clk);
    issue_d(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF); wait_d();
    d_write_en = 1'b0;
    @(negedge clk);
    issue_d(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678); wait_d();
    d_read_en = 1'b0; d_write_en = 1'b0;
    @(negedge clk);
    issue_d(1'b1, 1'b0, 32'h0000_0040, 32'h0); wait_d();
    d_read_en = 1'b0;

    // contention from the same cycle
    repeat (2) @(negedge clk);
    issue_i(32'h0000_0048);
    issue_d(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    fork
      begin wait_i(); i_read_en = 1'b0; end
      begin wait_d(); d_read_en = 1'b0; end
    join

    // both requests held continuously
    repeat (2) @(negedge clk);
    fork
      begin repeat (2) begin issue_i(32'h0000_0050); wait_i(); end i_read_en = 1'b0; end
      begin repeat (2) begin issue_d(1'b1, 1'b0, 32'h0000_0054, 32'h0); wait_d(); end d_read_en = 1'b0; end
    join

    // reset during the first access cycle of a load
    repeat (2) @(negedge clk);
    d_read_en = 1'b1; d_addr = 32'h0000_004C;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_m_read_en", 64'(m_read_en), 64'd0);
    chk("rstmid_m_addr", 64'(m_addr), 64'd0);
    chk("rstmid_d_ready", 64'(d_ready), 64'd0);
    d_read_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_d_ready", 64'(d_ready), 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    issue_i(32'h0000_0104); wait_i(); i_read_en = 1'b0;

    // randomized traffic on both ports
    @(negedge clk);
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue_i($urandom & 32'hFFFF_FFFC);
          wait_i();
          i_read_en = 1'b0;
        end
      end
      begin
        int kind;
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          kind = $urandom_range(0, 2);
          issue_d(kind != 1, kind != 0, $urandom & 32'hFFFF_FFFC, $urandom);
          wait_d();
          d_read_en = 1'b0; d_write_en = 1'b0;
        end
      end
    join

    repeat (6) @(negedge clk);
    chk("exp_i_drained", 64'(exp_i.size()), 64'd0);
    chk("exp_d_drained", 64'(exp_d.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
